// File: rtl/alu_pipe_if.sv
// ----------------------------------------------------------------------------
// alu_pipe_if
// Request/result bundle between the control path and the pipelined ALU.
//   InValid/InReady    : request handshake (issuer -> ALU)
//   FnSel              : function code
//   ALUSrcA/ALUSrcB    : operands (B also carries the shift amount)
//   CIn                : carry-in for IncB
//   OutValid/OutReady  : result handshake (ALU -> consumer)
//   ALUDataOut         : registered result
//   Flags              : registered {N,Z,C,V}
// master = issuer/consumer side, slave = ALU side.
// ----------------------------------------------------------------------------
interface alu_pipe_if #(
    parameter int DataWidth    = 32,
    parameter int FunctionSize = 4
);
    logic                    InValid;
    logic                    InReady;
    logic [FunctionSize-1:0] FnSel;
    logic [DataWidth-1:0]    ALUSrcA;
    logic [DataWidth-1:0]    ALUSrcB;
    logic                    CIn;
    logic                    OutValid;
    logic                    OutReady;
    logic [DataWidth-1:0]    ALUDataOut;
    logic [3:0]              Flags;

    modport master (
        output InValid, FnSel, ALUSrcA, ALUSrcB, CIn, OutReady,
        input  InReady, OutValid, ALUDataOut, Flags
    );

    modport slave (
        input  InValid, FnSel, ALUSrcA, ALUSrcB, CIn, OutReady,
        output InReady, OutValid, ALUDataOut, Flags
    );
endinterface

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
// Registered ALU with valid/ready handshakes on both sides, N/Z/C/V flags,
// variable shifts and rotate, and an iterative shift-add multiply.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : alu_pipe_if.slave (request, operands, result, flags)
// Single-cycle ops land in the output register on the accept edge. Mul
// spends DataWidth edges in the MUL state, one multiplier bit per edge.
// ----------------------------------------------------------------------------
module alu_pipe #(
    parameter int DataWidth    = 32,
    parameter int FunctionSize = 4,
    parameter int ShiftWidth   = 5
) (
    input  logic       clock,
    input  logic       reset,
    alu_pipe_if.slave  bus
);
    localparam logic [FunctionSize-1:0] FnAdd   = FunctionSize'(0);
    localparam logic [FunctionSize-1:0] FnSub   = FunctionSize'(1);
    localparam logic [FunctionSize-1:0] FnPassB = FunctionSize'(2);
    localparam logic [FunctionSize-1:0] FnIncB  = FunctionSize'(3);
    localparam logic [FunctionSize-1:0] FnShtR  = FunctionSize'(4);
    localparam logic [FunctionSize-1:0] FnShtL  = FunctionSize'(5);
    localparam logic [FunctionSize-1:0] FnAnd   = FunctionSize'(6);
    localparam logic [FunctionSize-1:0] FnOr    = FunctionSize'(7);
    localparam logic [FunctionSize-1:0] FnXor   = FunctionSize'(8);
    localparam logic [FunctionSize-1:0] FnCom   = FunctionSize'(9);
    localparam logic [FunctionSize-1:0] FnSwp   = FunctionSize'(10);
    localparam logic [FunctionSize-1:0] FnNop   = FunctionSize'(11);
    localparam logic [FunctionSize-1:0] FnRot   = FunctionSize'(12);
    localparam logic [FunctionSize-1:0] FnMul   = FunctionSize'(13);

    localparam logic [ShiftWidth-1:0] LastIter = ShiftWidth'(DataWidth - 1);
    localparam int Msb = DataWidth - 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t state;
    state_t nextState;

    logic inReady;
    logic accept;
    logic drain;
    logic isMul;
    logic mulStart;
    logic mulDone;
    logic loadSingle;

    logic [DataWidth-1:0]  srcA;
    logic [DataWidth-1:0]  srcB;
    logic [ShiftWidth-1:0] amt;
    logic [ShiftWidth-1:0] negAmt;

    logic [DataWidth:0]    sum;
    logic [DataWidth:0]    diff;
    logic [DataWidth:0]    incSum;
    logic [DataWidth:0]    shrWide;
    logic [DataWidth:0]    shlWide;

    logic [DataWidth-1:0]  aluRes;
    logic                  aluCarry;
    logic                  aluOvf;
    logic [3:0]            aluFlags;

    logic [DataWidth-1:0]  mulA;
    logic [DataWidth-1:0]  mulB;
    logic [DataWidth-1:0]  mulAcc;
    logic [DataWidth-1:0]  mulRes;
    logic [ShiftWidth-1:0] counter;

    assign srcA   = bus.ALUSrcA;
    assign srcB   = bus.ALUSrcB;
    assign amt    = srcB[ShiftWidth-1:0];
    // Rotate-right by amt is (A >> amt) | (A << (DW - amt)); taking DW - amt
    // modulo DW keeps an amount of 0 from shifting the whole word away.
    assign negAmt = ~amt + ShiftWidth'(1);

    // One extra bit on every add/sub/shift captures carry, borrow or the
    // last bit shifted out; an amount of 0 leaves that bit clear.
    assign sum     = {1'b0, srcA} + {1'b0, srcB};
    assign diff    = {1'b0, srcA} - {1'b0, srcB};
    assign incSum  = {1'b0, srcB} + {{DataWidth{1'b0}}, bus.CIn};
    assign shrWide = {srcA, 1'b0} >> amt;
    assign shlWide = {1'b0, srcA} << amt;

    assign isMul      = (bus.FnSel == FnMul);
    assign accept     = bus.InValid & inReady;
    assign drain      = bus.OutValid & bus.OutReady;
    assign mulStart   = accept & isMul;
    assign loadSingle = accept & ~isMul;

    // Partial-product step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign mulRes = mulAcc + (mulB[0] ? mulA : '0);

    // ---------------------------------------------------------------- ALU ---
    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves a value unassigned and no latch is inferred.
        aluRes   = sum[DataWidth-1:0];
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        case (bus.FnSel)
            FnSub: begin
                aluRes   = diff[DataWidth-1:0];
                aluCarry = diff[DataWidth];
                aluOvf   = (srcA[Msb] != srcB[Msb]) && (diff[Msb] != srcA[Msb]);
            end
            FnPassB, FnNop: aluRes = srcB;
            FnIncB: begin
                aluRes   = incSum[DataWidth-1:0];
                aluCarry = incSum[DataWidth];
            end
            FnShtR: begin
                aluRes   = shrWide[DataWidth:1];
                aluCarry = shrWide[0];
            end
            FnShtL: begin
                aluRes   = shlWide[DataWidth-1:0];
                aluCarry = shlWide[DataWidth];
            end
            FnAnd: aluRes = srcA & srcB;
            FnOr:  aluRes = srcA | srcB;
            FnXor: aluRes = srcA ^ srcB;
            FnCom: aluRes = ~srcB;
            FnSwp: aluRes = {srcB[DataWidth/2-1:0], srcB[DataWidth-1:DataWidth/2]};
            FnRot: aluRes = (srcA >> amt) | (srcA << negAmt);
            default: begin
                // Add, plus the unused codes 14/15 that alias to it.
                aluCarry = sum[DataWidth];
                aluOvf   = (srcA[Msb] == srcB[Msb]) && (sum[Msb] != srcA[Msb]);
            end
        endcase
        aluFlags = {aluRes[Msb], (aluRes == '0), aluCarry, aluOvf};
    end

    // ---------------------------------------------------------- FSM: state ---
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of block order.
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // ----------------------------------------------------- FSM: next state ---
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (mulStart) nextState = MUL;
            MUL:     if (mulDone)  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // --------------------------------------------------------- FSM: outputs ---
    always_comb begin
        inReady = (state == IDLE) && (!bus.OutValid || bus.OutReady);
        mulDone = (state == MUL) && (counter == LastIter);
    end

    assign bus.InReady = inReady;

    // -------------------------------------------------- multiply datapath ---
    always_ff @(posedge clock) begin
        if (!reset) begin
            mulA    <= '0;
            mulB    <= '0;
            mulAcc  <= '0;
            counter <= '0;
        end else if (mulStart) begin
            mulA    <= srcA;
            mulB    <= srcB;
            mulAcc  <= '0;
            counter <= '0;
        end else if (state == MUL) begin
            // Counter wraps to 0 on the final edge, ready for the next Mul.
            mulAcc  <= mulRes;
            mulA    <= mulA << 1;
            mulB    <= mulB >> 1;
            counter <= counter + ShiftWidth'(1);
        end
    end

    // ----------------------------------------------------- output register ---
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.OutValid   <= 1'b0;
            bus.ALUDataOut <= '0;
            bus.Flags      <= 4'b0000;
        end else begin
            if (loadSingle) begin
                bus.ALUDataOut <= aluRes;
                bus.Flags      <= aluFlags;
            end else if (mulDone) begin
                bus.ALUDataOut <= mulRes;
                bus.Flags      <= {mulRes[Msb], (mulRes == '0), 2'b00};
            end

            // A load wins over a simultaneous drain so OutValid stays high.
            if (loadSingle || mulDone) bus.OutValid <= 1'b1;
            else if (drain)            bus.OutValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_pipe
// Directed bench for alu_pipe (DataWidth=32). Inputs change 1 time unit after
// each rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_alu_pipe;
    logic clock;
    logic reset;
    int   testCount;
    int   failCount;

    alu_pipe_if #(.DataWidth(32), .FunctionSize(4)) bus ();

    alu_pipe #(
        .DataWidth(32),
        .FunctionSize(4),
        .ShiftWidth(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [3:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input logic cin);
        bus.InValid = 1'b1;
        bus.FnSel   = fn;
        bus.ALUSrcA = a;
        bus.ALUSrcB = b;
        bus.CIn     = cin;
    endtask

    // Single-cycle op with OutReady=1: accept on the next edge, then check.
    task automatic singleOp(input string tag, input logic [3:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic [31:0] expData,
                            input logic [3:0] expFlags);
        present(fn, a, b, cin);
        tick();
        bus.InValid = 1'b0;
        check({tag, " valid"}, 32'(bus.OutValid), 32'd1);
        check({tag, " data"},  bus.ALUDataOut,     expData);
        check({tag, " flags"}, 32'(bus.Flags),     32'(expFlags));
    endtask

    initial begin
        testCount   = 0;
        failCount   = 0;
        reset       = 1'b0;
        bus.OutReady = 1'b1;
        present(4'd0, 32'h1, 32'h1, 1'b0);

        // Reset held for two edges with a request pending.
        tick();
        tick();
        check("reset OutValid", 32'(bus.OutValid), 32'd0);
        check("reset data",     bus.ALUDataOut,     32'd0);
        check("reset flags",    32'(bus.Flags),     32'd0);
        reset       = 1'b1;
        bus.InValid = 1'b0;
        #1;
        check("InReady after reset", 32'(bus.InReady), 32'd1);

        // Arithmetic, logic, shift, rotate, swap. Flags are {N,Z,C,V}.
        singleOp("add wrap",  4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110);
        singleOp("sub ovf",   4'd1,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 4'b1011);
        singleOp("sub zero",  4'd1,  32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0100);
        singleOp("incb",      4'd3,  32'h0000_0000, 32'h0000_0010, 1'b1, 32'h0000_0011, 4'b0000);
        singleOp("shtl",      4'd5,  32'h8000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 4'b0010);
        singleOp("shtr 2",    4'd4,  32'h0000_000F, 32'h0000_0002, 1'b0, 32'h0000_0003, 4'b0010);
        singleOp("shtr 32",   4'd4,  32'hDEAD_BEEF, 32'h0000_0020, 1'b0, 32'hDEAD_BEEF, 4'b1000);
        singleOp("rot",       4'd12, 32'h0000_0001, 32'h0000_0004, 1'b0, 32'h1000_0000, 4'b0000);
        singleOp("swp",       4'd10, 32'h0000_0000, 32'h1234_ABCD, 1'b0, 32'hABCD_1234, 4'b1000);
        singleOp("xor",       4'd8,  32'hF0F0_0F0F, 32'hFF00_FF00, 1'b0, 32'h0FF0_F00F, 4'b0000);
        singleOp("com",       4'd9,  32'h0000_0000, 32'h0000_FFFF, 1'b0, 32'hFFFF_0000, 4'b1000);
        singleOp("code15",    4'd15, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 4'b0000);

        // Mul: the previous result drains on the accept edge; a second
        // request held during MUL must wait for completion.
        present(4'd13, 32'h0001_0003, 32'h0000_0005, 1'b0);
        tick();
        present(4'd0, 32'h0000_0002, 32'h0000_0003, 1'b0);
        check("mul drained", 32'(bus.OutValid), 32'd0);
        check("mul busy",    32'(bus.InReady),  32'd0);
        for (int i = 1; i < 32; i++) begin
            tick();
            check($sformatf("mul wait %0d valid", i), 32'(bus.OutValid), 32'd0);
            check($sformatf("mul wait %0d ready", i), 32'(bus.InReady),  32'd0);
        end
        tick();
        check("mul valid", 32'(bus.OutValid), 32'd1);
        check("mul data",  bus.ALUDataOut,     32'h0005_000F);
        check("mul flags", 32'(bus.Flags),     32'd0);
        check("mul idle",  32'(bus.InReady),   32'd1);
        tick();
        bus.InValid = 1'b0;
        check("post-mul add", bus.ALUDataOut, 32'h0000_0005);

        // Backpressure: three Adds, consumer stalls after the first.
        present(4'd0, 32'd1, 32'd1, 1'b0);
        tick();
        check("bp first", bus.ALUDataOut, 32'd2);
        bus.OutReady = 1'b0;
        present(4'd0, 32'd10, 32'd20, 1'b0);
        #1;
        check("bp stall ready", 32'(bus.InReady), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("bp hold %0d data", i),  bus.ALUDataOut,     32'd2);
            check($sformatf("bp hold %0d valid", i), 32'(bus.OutValid),  32'd1);
            check($sformatf("bp hold %0d ready", i), 32'(bus.InReady),   32'd0);
        end
        bus.OutReady = 1'b1;
        #1;
        check("bp release ready", 32'(bus.InReady), 32'd1);
        tick();
        check("bp second", bus.ALUDataOut, 32'd30);
        check("bp second valid", 32'(bus.OutValid), 32'd1);
        present(4'd0, 32'd100, 32'd200, 1'b0);
        tick();
        bus.InValid = 1'b0;
        check("bp third", bus.ALUDataOut, 32'd300);
        tick();
        check("bp drained", 32'(bus.OutValid), 32'd0);
        check("bp retained", bus.ALUDataOut,   32'd300);

        // Reset at iteration 10 of a Mul aborts it.
        present(4'd13, 32'd3, 32'd7, 1'b0);
        tick();
        bus.InValid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("abort valid", 32'(bus.OutValid), 32'd0);
        check("abort idle",  32'(bus.InReady),  32'd1);
        for (int i = 0; i < 25; i++) begin
            tick();
            check($sformatf("abort quiet %0d", i), 32'(bus.OutValid), 32'd0);
        end
        present(4'd0, 32'd4, 32'd5, 1'b0);
        tick();
        bus.InValid = 1'b0;
        check("after abort valid", 32'(bus.OutValid), 32'd1);
        check("after abort data",  bus.ALUDataOut,     32'd9);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the datapath ALU.
- Adds a valid/ready handshake on input and output, N/Z/C/V status flags, and variable-amount shifts and rotate.
- Adds an iterative multi-cycle multiply.
- Sits between register-file read and writeback; the control FSM issues one function code per operation and stalls on InReady.

Parameters:
- DataWidth, 32, operand/result width; even, >= 8.
- FunctionSize, 4, width of FnSel.
- ShiftWidth, 5, shift-amount bits taken from ALUSrcB; equals log2(DataWidth).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- InValid  in  1  operation request.
- InReady  out  1  block can accept a request this cycle.
- FnSel  in  FunctionSize  function code.
- ALUSrcA  in  DataWidth  operand A.
- ALUSrcB  in  DataWidth  operand B / shift amount.
- CIn  in  1  carry-in, used by IncB.
- OutValid  out  1  result register holds an unconsumed result.
- OutReady  in  1  consumer takes the result this cycle.
- ALUDataOut  out  DataWidth  registered result.
- Flags  out  4  registered {N,Z,C,V}.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset sampled low at a rising edge: OutValid=0, ALUDataOut=0, Flags=0, FSM=IDLE, iteration counter=0.
  - Reset mid-multiply aborts it; no result is produced.
- Transfers:
  - Accept = InValid & InReady at a rising edge.
  - Drain = OutValid & OutReady at a rising edge.
  - InReady = (FSM==IDLE) & (!OutValid | OutReady). Combinational, never depends on InValid.
  - ALUDataOut and Flags hold stable while OutValid & !OutReady.
  - Drain with no new load: OutValid -> 0, data retained.
- Function codes (applied to the operands sampled at accept):
  - 0 Add: A+B.
  - 1 Sub: A-B.
  - 2 PassB: B.
  - 3 IncB: B+CIn.
  - 4 ShtR: A >> B[ShiftWidth-1:0], logical.
  - 5 ShtL: A << B[ShiftWidth-1:0].
  - 6 And: A&B.
  - 7 Or: A|B.
  - 8 Xor: A^B.
  - 9 Com: ~B.
  - 10 Swp: {B[DW/2-1:0], B[DW-1:DW/2]}.
  - 11 Nop: B.
  - 12 Rot: A rotated right by B[ShiftWidth-1:0].
  - 13 Mul: low DataWidth bits of A*B, unsigned.
  - 14, 15: treated as Add.
- Single-cycle ops (all except Mul):
  - Accepted at edge k: result and flags registered at edge k; OutValid=1 after edge k.
  - Back-to-back accept every cycle when OutReady=1.
- Mul state machine, states IDLE and MUL:
  - Accept in IDLE: latch A and B, clear accumulator, counter=0, go to MUL.
  - Each edge in MUL: shift-add one multiplier bit, LSB first; counter++.
  - At the edge where counter reaches DataWidth-1: load result to ALUDataOut, OutValid=1, go to IDLE.
  - Mul accepted at edge k gives OutValid high after edge k+DataWidth.
  - InReady=0 throughout MUL.
  - The output register is always empty at Mul completion: any pending result drained on the accept edge.
- Flags (registered with the result):
  - Z = (result==0).
  - N = result[DW-1].
  - Add/IncB: C = carry out; V = signed overflow (Add only, 0 for IncB).
  - Sub: C = borrow (A<B unsigned); V = signed overflow.
  - ShtR/ShtL: C = last bit shifted out, 0 if the amount is 0; V=0.
  - All other ops: C=0, V=0.
- Width rules:
  - Internal add/sub are DW+1 bits.
  - A shift amount of 0 returns A unchanged.
  - Only the low ShiftWidth bits of B are used, so an amount of DW wraps to 0.
- Simultaneous accept and drain in the same edge: old result leaves and new result loads; OutValid stays 1.

Test Plan:
- Reset: reset=0 for 2 edges with InValid=1 -> OutValid=0, ALUDataOut=0, Flags=0; InReady=1 on the first cycle after release.
- Arithmetic:
  - Add 0xFFFFFFFF+0x00000001 -> ALUDataOut=0, Flags N=0 Z=1 C=1 V=0.
  - Sub 0x7FFFFFFF-0xFFFFFFFF -> 0x80000000, N=1 C=1 V=1.
  - IncB B=0x10, CIn=1 -> 0x11.
- Shift/rotate/swap:
  - ShtL A=0x80000001, B=1 -> 0x00000002, C=1.
  - Rot A=0x00000001, B=4 -> 0x10000000.
  - Swp B=0x1234ABCD -> 0xABCD1234.
  - ShtR with B=32 -> A unchanged.
- Mul: A=0x00010003, B=0x00000005 -> 0x0005000F, OutValid high exactly 32 edges after accept; InReady=0 for those cycles; second InValid held meanwhile is accepted only after completion.
- Backpressure: 3 back-to-back Adds with OutReady=0 after the first -> first result held stable, InReady=0; on OutReady=1 the remaining results appear one per cycle in order, none lost or duplicated.
- Reset mid-Mul: reset=0 at iteration 10 -> OutValid stays 0, FSM=IDLE; next Add completes with latency 1.
